bcd_decoder_arbiter: RTL

- Round-robin arbiter and sequencer that shares one BCD-to-one-hot decoder among NREQ requesters.
- The shared decoder maps codes 0..9 to a one-hot 10-bit word and any code >9 to 10'h3FF.
- This block drives the decoder input, holds it stable, captures the decoder output, and returns the result with a one-cycle grant pulse to the winning requester.
- It sits between per-digit clients (display/scan logic) and the single shared decoder instance.

---
 rtl/bcd_decoder_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_decoder_arbiter.sv
// Round-robin arbiter/sequencer sharing one BCD-to-one-hot decoder among NREQ requesters.
// Ports:
//   iCLK, iRSTn        clock, asynchronous active-low reset
//   iREQ[NREQ]         per-requester request level
//   iCODE[4*NREQ]      packed BCD codes, requester k at [4k+3:4k]
//   oGNT[NREQ]         one-hot grant pulse, coincident with oVALID
//   oDEC_IN[4]         registered code driven to the shared decoder
//   iDEC_OUT[10]       shared decoder output
//   oRESULT[10]        captured decoder output of the last transaction
//   oVALID             1-cycle pulse when oRESULT/oERR are new
//   oERR               last captured code was above 9
//   oBUSY              high whenever the sequencer is not idle
module bcd_decoder_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic [NREQ-1:0]   iREQ,
  input  logic [4*NREQ-1:0] iCODE,
  output logic [NREQ-1:0]   oGNT,
  output logic [3:0]        oDEC_IN,
  input  logic [9:0]        iDEC_OUT,
  output logic [9:0]        oRESULT,
  output logic              oVALID,
  output logic              oERR,
  output logic              oBUSY
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, DONE} stateT;

  stateT            state, stateNx;
  logic [IW-1:0]    ptr, ptrNx;
  logic [IW-1:0]    idx, idxNx;
  logic [CW-1:0]    holdCnt, holdCntNx;
  logic [3:0]       decInNx;
  logic [9:0]       resultNx;
  logic             errNx;
  logic             validNx;
  logic [NREQ-1:0]  gntNx;

  logic             winHit;
  logic [IW-1:0]    winIdx;
  logic [3:0]       winCode;

  // Round-robin pick: first pass covers indices at/above ptr, second pass
  // catches the wrap-around (only indices below ptr can still be set then).
  always_comb begin
    winHit  = 1'b0;
    winIdx  = '0;
    winCode = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!winHit && iREQ[i] && (IW'(i) >= ptr)) begin
        winHit  = 1'b1;
        winIdx  = IW'(i);
        winCode = iCODE[4*i +: 4];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!winHit && iREQ[i]) begin
        winHit  = 1'b1;
        winIdx  = IW'(i);
        winCode = iCODE[4*i +: 4];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    stateNx   = state;
    ptrNx     = ptr;
    idxNx     = idx;
    holdCntNx = holdCnt;
    decInNx   = oDEC_IN;
    resultNx  = oRESULT;
    errNx     = oERR;
    validNx   = 1'b0;
    gntNx     = '0;
    case (state)
      IDLE: begin
        if (winHit) begin
          idxNx     = winIdx;
          decInNx   = winCode;
          holdCntNx = CW'(HOLD_CYC - 1);
          stateNx   = DRIVE;
        end
      end
      DRIVE: begin
        if (holdCnt == '0) stateNx = CAPT;
        else               holdCntNx = holdCnt - CW'(1);
      end
      CAPT: begin
        resultNx = iDEC_OUT;
        errNx    = (oDEC_IN > 4'd9);
        validNx  = 1'b1;
        gntNx    = NREQ'(1) << idx;
        ptrNx    = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
        stateNx  = DONE;
      end
      DONE:    stateNx = IDLE;
      default: stateNx = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      holdCnt <= '0;
      oDEC_IN <= '0;
      oRESULT <= '0;
      oERR    <= 1'b0;
      oVALID  <= 1'b0;
      oGNT    <= '0;
    end else begin
      state   <= stateNx;
      ptr     <= ptrNx;
      idx     <= idxNx;
      holdCnt <= holdCntNx;
      oDEC_IN <= decInNx;
      oRESULT <= resultNx;
      oERR    <= errNx;
      oVALID  <= validNx;
      oGNT    <= gntNx;
    end
  end

  assign oBUSY = (state != IDLE);

endmodule
